// File: rtl/quant_par_writer.sv
// Two-partition circular FIFO: independent queues for partition 0 and 1 sharing one write and one read port.
// Optional feature: define QUANT_PAR_SCRUB_EN to zero vacated slots on pop and force rd_data to 0 when empty.
module quant_par_writer #(
  parameter int unsigned DW    = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic                     wr_part,
  input  logic [DW-1:0]            wr_data,
  output logic                     wr_ready,
  input  logic                     rd_part,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count0,
  output logic [$clog2(DEPTH):0]   count1
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem0_q [DEPTH];
  logic [DW-1:0] mem1_q [DEPTH];

  logic [AW-1:0] wr_ptr0_q, wr_ptr0_d, rd_ptr0_q, rd_ptr0_d;
  logic [AW-1:0] wr_ptr1_q, wr_ptr1_d, rd_ptr1_q, rd_ptr1_d;
  logic [CW-1:0] count0_q, count0_d, count1_q, count1_d;

  logic not_full0, not_full1, not_empty0, not_empty1;
  logic push0, push1, pop0, pop1;
  logic [DW-1:0] head0, head1;

  // Occupancy flags per partition; each derived only from its own count.
  always_comb begin
    not_full0  = (count0_q != CW'(DEPTH));
    not_full1  = (count1_q != CW'(DEPTH));
    not_empty0 = (count0_q != CW'(0));
    not_empty1 = (count1_q != CW'(0));
    head0      = mem0_q[rd_ptr0_q];
    head1      = mem1_q[rd_ptr1_q];
  end

  // Port-level handshakes are steered by the public selectors wr_part / rd_part.
  always_comb begin
    wr_ready = wr_part ? not_full1 : not_full0;
    rd_valid = rd_part ? not_empty1 : not_empty0;
`ifdef QUANT_PAR_SCRUB_EN
    rd_data  = rd_part ? (not_empty1 ? head1 : '0) : (not_empty0 ? head0 : '0);
`else
    rd_data  = rd_part ? head1 : head0;
`endif
  end

  // A full partition still takes a write when the same edge pops it, keeping count at DEPTH.
  always_comb begin
    pop0  = rd_ready && !rd_part && not_empty0;
    pop1  = rd_ready &&  rd_part && not_empty1;
    push0 = wr_valid && !wr_part && (not_full0 || pop0);
    push1 = wr_valid &&  wr_part && (not_full1 || pop1);
  end

  // Next-state for pointers and counts; pointer width makes wrap modulo DEPTH implicit.
  always_comb begin
    wr_ptr0_d = wr_ptr0_q;
    rd_ptr0_d = rd_ptr0_q;
    wr_ptr1_d = wr_ptr1_q;
    rd_ptr1_d = rd_ptr1_q;
    count0_d  = count0_q;
    count1_d  = count1_q;
    if (push0) wr_ptr0_d = wr_ptr0_q + AW'(1);
    if (pop0)  rd_ptr0_d = rd_ptr0_q + AW'(1);
    if (push1) wr_ptr1_d = wr_ptr1_q + AW'(1);
    if (pop1)  rd_ptr1_d = rd_ptr1_q + AW'(1);
    count0_d = count0_q + CW'(push0) - CW'(pop0);
    count1_d = count1_q + CW'(push1) - CW'(pop1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr0_q <= '0;
      rd_ptr0_q <= '0;
      wr_ptr1_q <= '0;
      rd_ptr1_q <= '0;
      count0_q  <= '0;
      count1_q  <= '0;
    end else begin
      wr_ptr0_q <= wr_ptr0_d;
      rd_ptr0_q <= rd_ptr0_d;
      wr_ptr1_q <= wr_ptr1_d;
      rd_ptr1_q <= rd_ptr1_d;
      count0_q  <= count0_d;
      count1_q  <= count1_d;
    end
  end

  // Storage is not reset; a write to the slot being vacated wins over the scrub.
  always_ff @(posedge clk) begin
`ifdef QUANT_PAR_SCRUB_EN
    if (pop0) mem0_q[rd_ptr0_q] <= '0;
    if (pop1) mem1_q[rd_ptr1_q] <= '0;
`endif
    if (push0) mem0_q[wr_ptr0_q] <= wr_data;
    if (push1) mem1_q[wr_ptr1_q] <= wr_data;
  end

  assign count0 = count0_q;
  assign count1 = count1_q;

endmodule
